// File: rtl/cardinal_pkg.sv
// Shared cardinal-family definitions: PPP lane-select modes, opcodes and the lane mask helper.
// Lane k is byte k counted from the MSB end of the word (bit 0 is the MSB).
package cardinal_pkg;

    localparam int unsigned MAX_NB = 64;

    localparam logic [2:0] PPP_A = 3'b000;
    localparam logic [2:0] PPP_U = 3'b001;
    localparam logic [2:0] PPP_D = 3'b010;
    localparam logic [2:0] PPP_E = 3'b011;
    localparam logic [2:0] PPP_O = 3'b100;

    typedef enum logic [3:0] {
        OpNop,
        OpAdd,
        OpSub,
        OpAnd,
        OpOr,
        OpXor,
        OpLoad,
        OpStore
    } cardinal_op_e;

    // Bit k of the result enables lane k; modes 101-111 enable nothing.
    function automatic logic [MAX_NB-1:0] ppp_lane_mask(input logic [2:0] ppp,
                                                        input int unsigned nb);
        logic [MAX_NB-1:0] mask;
        mask = '0;
        for (int unsigned k = 0; k < MAX_NB; k++) begin
            if (k < nb) begin
                case (ppp)
                    PPP_A:   mask[k] = 1'b1;
                    PPP_U:   mask[k] = (k < nb / 2);
                    PPP_D:   mask[k] = (k >= nb / 2);
                    PPP_E:   mask[k] = ((k % 2) == 0);
                    PPP_O:   mask[k] = ((k % 2) == 1);
                    default: mask[k] = 1'b0;
                endcase
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/cardinal_sb_counter.sv
// Per-register pending-write counter: saturating up/down with an underflow pulse.
module cardinal_sb_counter #(
    parameter int unsigned PEND_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] count,
    output logic              underflow
);

    logic [PEND_W-1:0] count_q, count_d;

    always_comb begin
        count_d   = count_q;
        underflow = 1'b0;
        if (inc && !dec) begin
            if (count_q != '1) count_d = count_q + PEND_W'(1);
        end else if (dec && !inc) begin
            if (count_q == '0) underflow = 1'b1;
            else               count_d   = count_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/cardinal_regfile_sb.sv
// Register file with byte-lane partial writes, merged write-through bypass and a
// per-register pending-write scoreboard. Vectors are MSB-first: port/lane 0 is leftmost.
module cardinal_regfile_sb
    import cardinal_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned PEND_W     = 2,
    localparam int unsigned AW        = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_RD*AW-1:0]         rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         iss_valid,
    input  logic [AW-1:0]                iss_addr,
    output logic                         iss_ready,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [2:0]                   wr_ppp,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         err_underflow
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [PEND_W-1:0]     pend   [NUM_REGS];
    logic [NUM_REGS-1:0]   underflow;
    logic [NB-1:0]         lane_en;
    logic [DATA_WIDTH-1:0] wr_bits;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic                  iss_fire;
    logic                  err_q;

    assign lane_en = NB'(ppp_lane_mask(wr_ppp, NB));

    always_comb begin
        wr_bits = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            wr_bits[DATA_WIDTH-1-8*k -: 8] = {8{lane_en[k]}};
        end
    end

    assign wr_merged = (regs_q[wr_addr] & ~wr_bits) | (wr_data & wr_bits);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else if (wr_en) begin
            regs_q[wr_addr] <= wr_merged;
        end
    end

    // A retire in the same cycle frees the slot the issue needs.
    assign iss_ready = (pend[iss_addr] != '1) || (wr_en && (wr_addr == iss_addr));
    assign iss_fire  = iss_valid && iss_ready;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
        cardinal_sb_counter #(
            .PEND_W(PEND_W)
        ) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .inc      (iss_fire && (iss_addr == AW'(r))),
            .dec      (wr_en && (wr_addr == AW'(r))),
            .count    (pend[r]),
            .underflow(underflow[r])
        );
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]         addr;
        logic                  hit;
        logic [DATA_WIDTH-1:0] stored;

        assign addr   = rd_addr[(NUM_RD-i)*AW-1 -: AW];
        assign hit    = wr_en && (addr == wr_addr);
        assign stored = regs_q[addr];

        assign rd_data[(NUM_RD-i)*DATA_WIDTH-1 -: DATA_WIDTH] =
            hit ? ((stored & ~wr_bits) | (wr_data & wr_bits)) : stored;
        // The retiring write satisfies one outstanding reservation.
        assign rd_busy[NUM_RD-1-i] = pend[addr] > (hit ? PEND_W'(1) : PEND_W'(0));
    end

    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_q | (|underflow);
    end

    assign err_underflow = err_q;

endmodule

// File: doc/cardinal_regfile_sb.md
Name: cardinal_regfile_sb

Overview:
Parametrised register file with scoreboard, the next-generation datapath core for cardinal-family processors.
- Adds what the current 3-stage core lacks: N read ports, PPP sub-field (byte-lane) partial writes with write-through bypass, and per-register pending-write tracking.
- The tracking lets multi-cycle producers (NIC loads, multi-cycle ALU ops) stall dependents without pipeline-specific compare logic.
- Sits between ID (read, issue) and WB (retire/write).

Parameters:
DATA_WIDTH, 64, register width in bits; must be a multiple of 16.
NUM_REGS, 32, number of registers; power of two.
NUM_RD, 2, number of combinational read ports.
PEND_W, 2, per-register pending-write counter width; max outstanding writes per register is 2^PEND_W-1.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rd_addr  in  NUM_RD*AW  read addresses, port i at slice [i*AW:(i+1)*AW-1], AW=log2(NUM_REGS)
rd_data  out  NUM_RD*DATA_WIDTH  read data, same slicing
rd_busy  out  NUM_RD  port i source has an unretired write not satisfied by this cycle's bypass
iss_valid  in  1  reserve destination iss_addr
iss_addr  in  AW  destination being reserved
iss_ready  out  1  reservation can be accepted
wr_en  in  1  retire/write
wr_addr  in  AW  write destination
wr_ppp  in  3  lane-select mode
wr_data  in  DATA_WIDTH  write data
err_underflow  out  1  sticky: retire seen on a register with zero pending count

Behaviour:
- Bit order [0:DATA_WIDTH-1]; bit 0 is the MSB. Byte lane k = bits [8k:8k+7]; NB = DATA_WIDTH/8 lanes.
- PPP lane enables:
  - 000 a: all lanes.
  - 001 u: lanes 0..NB/2-1.
  - 010 d: lanes NB/2..NB-1.
  - 011 e: even k.
  - 100 o: odd k.
  - 101-111: no lanes written. The retire still decrements the scoreboard.
- Write: at posedge when wr_en=1, enabled lanes of reg[wr_addr] take wr_data. Disabled lanes hold their value. Latency 1 cycle.
- Read: combinational. If wr_en=1 and rd_addr==wr_addr, rd_data = enabled lanes from wr_data, other lanes from the stored value (merged bypass). Otherwise the stored value.
- Scoreboard: counter pend[r], PEND_W bits.
  - iss_ready = (pend[iss_addr] != max) || (wr_en && wr_addr==iss_addr). A same-cycle retire frees a slot.
  - Issue accepted = iss_valid && iss_ready.
  - Accepted issue only: pend+1.
  - Retire only (wr_en, pend>0): pend-1.
  - Issue and retire to the same register in the same cycle: pend unchanged.
  - Issue and retire to different registers: each updated independently.
  - Retire with pend==0 (and no same-cycle issue to that register): pend stays 0; err_underflow set to 1 next cycle and held until reset.
- rd_busy[i] = pend[rd_addr_i] > n, where n=1 if wr_en && wr_addr==rd_addr_i, else 0.
  - Reflects pre-edge state only; same-cycle issue does not raise rd_busy.
- iss_valid with iss_ready=0 is ignored; the requester must hold and retry.
- Reset (any cycle, including with pending writes): all registers 0, all pend 0, err_underflow 0; wr_en/iss_valid in that cycle ignored.
  - Outputs after reset: rd_data=0, rd_busy=0, iss_ready=1, except the combinational bypass on rd_data when wr_en is asserted.
- No hardwired zero register; reg 0 is writable.

Decomposition:
- Shared package cardinal_pkg: PPP mode constants (PPP_A..PPP_O), opcode constants, and the function ppp_lane_mask(ppp, NB), also reused by ALU and WB.
- One sub-module: cardinal_sb_counter, a per-register saturating up/down counter with an underflow pulse, instantiated NUM_REGS times via generate.

Test Plan:
- Reset then read all 32 regs on both ports -> rd_data=0, rd_busy=0, iss_ready=1, err_underflow=0.
- Write r5=0x0123456789ABCDEF, PPP=a; next cycle write r5=0xFFFFFFFFFFFFFFFF, PPP=e; read r5 the same cycle as the second write -> 0xFF23FF67FFABFFEF (bypass). Read next cycle -> same value.
- Write r7=0x1111111111111111 (a). Then wr r7=0x2222222222222222 with PPP=u, read -> 0x2222222211111111. Then PPP=d -> 0x2222222222222222. Then PPP=110 -> unchanged.
- Issue r3 three times (PEND_W=2) -> iss_ready low for r3 on the 4th attempt, rd_busy=1 on r3. A 4th issue concurrent with a retire to r3 is accepted, pend stays 3. Two further retires -> pend 1, rd_busy still 1. In the cycle of the final retire, a port reading r3 sees rd_busy=0 and the bypassed data.
- Issue r4 and retire r9 in the same cycle, with pend[9]=1 -> pend[4]=1, pend[9]=0. Then retire r9 again -> err_underflow=1 and stays high across 10 idle cycles.
- With pend[2]=2 and r2=0xAA.., assert reset mid-stream with wr_en=1 to r2 -> next cycle r2=0, pend[2]=0, rd_busy=0.
